// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU ops,
// state numbering, datapath mux selects and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BEQ      = 4'd8,
    ST_IMM_EX   = 4'd9,
    ST_IMM_WB   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       ext_zero;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // ALU operation for the I-type arithmetic group; anything else adds.
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] r;
    case (op)
      OP_ANDI: r = ALU_AND;
      OP_ORI:  r = ALU_OR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Logical immediates take a zero-extended operand, arithmetic ones sign-extend.
  function automatic logic imm_zero_ext(input logic [5:0] op);
    logic r;
    case (op)
      OP_ANDI, OP_ORI: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct field to ALU operation, with a flag for functs the core supports.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_valid
);

  // Pure lookup; unsupported functs report invalid and fall back to add.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_valid    = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: begin
        o_alu_ctrl = ALU_ADD;
        o_valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/memory/writeback
// sequencing with a mem_ready stall handshake.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUW   = 4,
  parameter int STATEW = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic              i_zero,
  input  logic              i_mem_ready,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_iord,
  output logic              o_ir_write,
  output logic              o_pc_write,
  output logic              o_pc_write_cond,
  output logic [1:0]        o_pc_src,
  output logic              o_alu_src_a,
  output logic [1:0]        o_alu_src_b,
  output logic [ALUW-1:0]   o_alu_ctrl,
  output logic              o_ext_zero,
  output logic              o_reg_dst,
  output logic              o_mem_to_reg,
  output logic              o_reg_write,
  output logic              o_illegal,
  output logic [STATEW-1:0] o_state
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_run;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic [3:0] w_fn_alu;
  logic       w_fn_valid;
  logic       w_unused_zero;

  // The branch decision is taken by the datapath from pc_write_cond and zero.
  assign w_unused_zero = i_zero;

  mips_alu_decode u_alu_decode (
    .i_funct    (i_funct),
    .o_alu_ctrl (w_fn_alu),
    .o_valid    (w_fn_valid)
  );

  // State register; r_run holds all outputs low until the first edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  // Next-state and Moore control decode; only the fetch strobes follow mem_ready.
  always_comb begin
    w_next_state = ST_FETCH;
    w_ctrl       = CTRL_IDLE;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_ctrl  = ALU_ADD;
        if (i_mem_ready && r_run) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PCSRC_ALU;
          w_next_state    = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_ctrl  = ALU_ADD;
        case (i_opcode)
          OP_LW, OP_SW:              w_next_state = ST_MEMADR;
          OP_RTYPE:                  w_next_state = ST_RTYPE_EX;
          OP_BEQ:                    w_next_state = ST_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  w_next_state = ST_IMM_EX;
          OP_J:                      w_next_state = ST_JUMP;
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next_state   = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_ctrl  = ALU_ADD;
        if (i_opcode == OP_LW) begin
          w_next_state = ST_MEMRD;
        end else if (i_opcode == OP_SW) begin
          w_next_state = ST_MEMWR;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (i_mem_ready) begin
          w_next_state = ST_MEMWB;
        end else begin
          w_next_state = ST_MEMRD;
        end
      end
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next_state      = ST_FETCH;
      end
      ST_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (i_mem_ready) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_MEMWR;
        end
      end
      ST_RTYPE_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_ctrl  = w_fn_alu;
        if (w_fn_valid) begin
          w_next_state = ST_RTYPE_WB;
        end else begin
          w_ctrl.illegal = 1'b1;
          w_next_state   = ST_FETCH;
        end
      end
      ST_RTYPE_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next_state     = ST_FETCH;
      end
      ST_BEQ: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_REGB;
        w_ctrl.alu_ctrl      = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_src        = PCSRC_ALUOUT;
        w_next_state         = ST_FETCH;
      end
      ST_IMM_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_ctrl  = imm_alu_op(i_opcode);
        w_ctrl.ext_zero  = imm_zero_ext(i_opcode);
        w_next_state     = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctrl  = imm_alu_op(i_opcode);
        w_ctrl.ext_zero  = imm_zero_ext(i_opcode);
        w_next_state     = ST_FETCH;
      end
      ST_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_next_state    = ST_FETCH;
      end
      default: begin
        w_ctrl.illegal = 1'b1;
        w_next_state   = ST_FETCH;
      end
    endcase
  end

  // Quiet control word until the controller has seen a clock out of reset.
  always_comb begin
    if (r_run) begin
      w_out = w_ctrl;
    end else begin
      w_out = CTRL_IDLE;
    end
  end

  assign o_mem_read      = w_out.mem_read;
  assign o_mem_write     = w_out.mem_write;
  assign o_iord          = w_out.iord;
  assign o_ir_write      = w_out.ir_write;
  assign o_pc_write      = w_out.pc_write;
  assign o_pc_write_cond = w_out.pc_write_cond;
  assign o_pc_src        = w_out.pc_src;
  assign o_alu_src_a     = w_out.alu_src_a;
  assign o_alu_src_b     = w_out.alu_src_b;
  assign o_alu_ctrl      = ALUW'(w_out.alu_ctrl);
  assign o_ext_zero      = w_out.ext_zero;
  assign o_reg_dst       = w_out.reg_dst;
  assign o_mem_to_reg    = w_out.mem_to_reg;
  assign o_reg_write     = w_out.reg_write;
  assign o_illegal       = w_out.illegal;
  assign o_state         = STATEW'(r_state);

endmodule
